// File: rtl/cs_window_ctrl.sv
// Stream sequencer for the CS sliding-window core.
// Gates core shifts, tags full-window results and buffers them per frame.
module cs_window_ctrl #(
  parameter int WIN       = 9,
  parameter int XW        = 8,
  parameter int YW        = 10,
  parameter int CORE_LAT  = 1,
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XW-1:0]    in_data,
  input  logic             in_last,
  output logic [XW-1:0]    core_x,
  output logic             core_shift,
  output logic             core_clear,
  input  logic [YW-1:0]    core_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [YW-1:0]    out_data,
  output logic             out_last,
  output logic             busy,
  output logic             err_short,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int FW = $clog2(WIN + 1);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int IW = $clog2(CORE_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, FILL, RUN, FLUSH, CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [CORE_LAT-1:0] tag_v_q, tag_v_d;
  logic [CORE_LAT-1:0] tag_l_q, tag_l_d;
  logic [YW-1:0]       mem_data_q [OUT_DEPTH];
  logic [YW-1:0]       mem_data_d [OUT_DEPTH];
  logic [OUT_DEPTH-1:0] mem_last_q, mem_last_d;
  logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]    frame_q, frame_d;
  logic                err_q, err_d;

  logic                open_st, accept, produce;
  logic                push, pop, short_end;
  logic [IW-1:0]       inflight;
  int                  occ;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake, credit check and result tagging decisions
  always_comb begin
    inflight = '0;
    for (int i = 0; i < CORE_LAT; i++)
      inflight = inflight + IW'(tag_v_q[i]);
    open_st   = (state_q == IDLE) || (state_q == FILL) ||
                (state_q == RUN);
    out_valid = (cnt_q != '0);
    pop       = out_valid & out_ready;
    occ       = int'(inflight) + int'(cnt_q) - int'(pop);
    in_ready  = !reset && open_st && (occ < OUT_DEPTH);
    accept    = in_valid & in_ready;
    produce   = accept && (fill_q >= FW'(WIN - 1));
    short_end = accept && in_last && (fill_q < FW'(WIN - 1));
    push      = tag_v_q[CORE_LAT-1];
  end

  // Tag pipeline tracking results still inside the core
  always_comb begin
    tag_v_d    = '0;
    tag_l_d    = '0;
    tag_v_d[0] = produce;
    tag_l_d[0] = produce & in_last;
    for (int i = 1; i < CORE_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_l_d[i] = tag_l_q[i-1];
    end
  end

  // Result FIFO next-state: push from tag exit, pop on handshake
  always_comb begin
    mem_data_d = mem_data_q;
    mem_last_d = mem_last_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    if (push) begin
      mem_data_d[wr_q] = core_y;
      mem_last_d[wr_q] = tag_l_q[CORE_LAT-1];
      wr_d             = nxt(wr_q);
    end
    if (pop) rd_d = nxt(rd_q);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Frame FSM, fill counter, clear pulse and frame counter
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    frame_d    = frame_q;
    core_clear = 1'b0;
    err_d      = short_end;
    if (accept && fill_q != FW'(WIN))
      fill_d = fill_q + 1'b1;
    unique case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if (in_last)
            state_d = FLUSH;
          else if (fill_q >= FW'(WIN - 1))
            state_d = RUN;
          else
            state_d = FILL;
        end
      end
      RUN: begin
        if (accept && in_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (inflight == '0 && cnt_q == '0)
          state_d = CLEAR;
      end
      CLEAR: begin
        core_clear = 1'b1;
        frame_d    = frame_q + 1'b1;
        fill_d     = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fill_q     <= '0;
      tag_v_q    <= '0;
      tag_l_q    <= '0;
      mem_last_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      frame_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++)
        mem_data_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      tag_v_q    <= tag_v_d;
      tag_l_q    <= tag_l_d;
      mem_last_q <= mem_last_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign core_x     = in_data;
  assign core_shift = accept;
  assign out_data   = mem_data_q[rd_q];
  assign out_last   = mem_last_q[rd_q];
  assign busy       = (state_q != IDLE);
  assign err_short  = err_q;
  assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_cs_window_ctrl.sv
// Bench for cs_window_ctrl with a behavioural CS core stand-in.
// Expected results come from the frame's sample list by plain arithmetic.
module tb_cs_window_ctrl;
  localparam int WIN = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data, core_x;
  logic        core_shift, core_clear;
  logic [9:0]  core_y, out_data;
  logic        out_valid, out_ready, out_last;
  logic        busy, err_short;
  logic [15:0] frame_cnt;

  cs_window_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .core_x(core_x), .core_shift(core_shift),
    .core_clear(core_clear), .core_y(core_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .err_short(err_short),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: y = sum of last WIN samples + 7*shifts since clear
  logic [7:0] cwin [WIN];
  int ccnt;
  int csum;
  always_comb begin
    csum = int'(core_x);
    for (int i = 0; i < WIN - 1; i++) csum += int'(cwin[i]);
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) cwin[i] <= '0;
      ccnt   <= 0;
      core_y <= '0;
    end else if (core_clear) begin
      for (int i = 0; i < WIN; i++) cwin[i] <= '0;
      ccnt <= 0;
    end else if (core_shift) begin
      for (int i = WIN - 1; i > 0; i--) cwin[i] <= cwin[i-1];
      cwin[0] <= core_x;
      ccnt    <= ccnt + 1;
      core_y  <= 10'(csum + 7 * (ccnt + 1));
    end
  end

  int n_chk, n_fail;
  int exp_q[$];
  int fs[$];
  int n_pop, n_err, n_clear;
  int acc9, ov_cyc;
  bit seen_ov, saw_bp;
  int rdy_mode, stall_req, stall_cnt;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Downstream ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else if (rdy_mode == 2)
        out_ready = ($urandom_range(0, 3) != 0);
      else
        out_ready = (rdy_mode == 0);
    end
  end

  // Output monitor and scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (core_clear) n_clear++;
      if (err_short) n_err++;
      if (in_valid && !in_ready) saw_bp = 1;
      if (out_valid && !seen_ov) begin
        seen_ov = 1;
        ov_cyc  = cyc;
        if (stall_req > 0) stall_cnt = stall_req;
      end
      if (out_valid && out_ready) begin
        n_pop++;
        check("result_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0)
          check("result", int'({out_last, out_data}), exp_q.pop_front());
      end
    end
  end

  task automatic put(input logic [7:0] d, input logic l);
    int t, k, s;
    bit ok;
    t = 0; ok = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!ok && t < 2000) begin
      @(negedge clk);
      if (in_ready) ok = 1; else t++;
    end
    check("accept", int'(ok), 1);
    if (ok) begin
      k = fs.size();
      fs.push_back(int'(d));
      if (k == WIN - 1) acc9 = cyc;
      if (k >= WIN - 1) begin
        s = 7 * (k + 1);
        for (int j = k - WIN + 1; j <= k; j++) s += fs[j];
        exp_q.push_back((int'(l) << 10) | (s % 1024));
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 1000);
    check("frame_done", int'(busy), 0);
  endtask

  task automatic run_frame(input int len, input int exp_res,
                           input int exp_err, input int exp_bp,
                           input bit use_bp, input int gap_max,
                           input bit rnd);
    int pop0, fc0, g;
    logic [7:0] d;
    @(posedge clk); #1;
    pop0 = n_pop; fc0 = int'(frame_cnt);
    n_err = 0; n_clear = 0; seen_ov = 0; saw_bp = 0;
    acc9 = -1; fs.delete();
    for (int i = 0; i < len; i++) begin
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) begin @(posedge clk); #1; end
      d = rnd ? 8'($urandom_range(0, 255)) : 8'(16 + i);
      put(d, i == len - 1);
    end
    wait_done();
    stall_req = 0;
    check("results", n_pop - pop0, exp_res);
    check("err_short", n_err, exp_err);
    check("core_clear", n_clear, 1);
    check("frame_cnt", int'(frame_cnt), (fc0 + 1) % 65536);
    check("sb_empty", exp_q.size(), 0);
    if (use_bp) check("backpressure", int'(saw_bp), exp_bp);
    if (len >= WIN) check("latency", ov_cyc - acc9, 2);
  endtask

  typedef struct {
    int len;
    int stall;
    int exp_res;
    int exp_err;
    int exp_bp;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int len;
    tbl[0] = '{12, 0, 4, 0, 0};
    tbl[1] = '{12, 6, 4, 0, 1};
    tbl[2] = '{5,  0, 0, 1, 0};
    tbl[3] = '{9,  0, 1, 0, 0};
    tbl[4] = '{1,  0, 0, 1, 0};
    tbl[5] = '{10, 3, 2, 0, 0};
    tbl[6] = '{20, 0, 12, 0, 0};

    n_chk = 0; n_fail = 0;
    rdy_mode = 0; stall_req = 0; stall_cnt = 0;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    in_data = 8'hA5;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_clear", int'(core_clear), 0);
    check("rst_err", int'(err_short), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_shift", int'(core_shift), 0);
    check("rst_core_x", int'(core_x), 'hA5);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 1);

    foreach (tbl[i]) begin
      stall_req = tbl[i].stall;
      run_frame(tbl[i].len, tbl[i].exp_res, tbl[i].exp_err,
                tbl[i].exp_bp, 1'b1, 0, 1'b0);
    end

    // Reset mid-frame with two results held in the FIFO
    @(posedge clk); #1;
    rdy_mode = 1; fs.delete(); n_clear = 0;
    for (int i = 0; i < 10; i++) put(8'(32 + i), 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pending_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_valid", int'(out_valid), 0);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_ready", int'(in_ready), 1);
    check("post_rst_frame_cnt", int'(frame_cnt), 0);
    check("post_rst_no_clear", n_clear, 0);
    rdy_mode = 0;
    run_frame(12, 4, 0, 0, 1'b0, 0, 1'b0);

    // Random frames, random gaps and random downstream ready
    rdy_mode = 2;
    for (int f = 0; f < 10; f++) begin
      len = $urandom_range(1, 40);
      run_frame(len, (len >= WIN) ? len - 8 : 0,
                (len < WIN) ? 1 : 0, 0, 1'b0, 2, 1'b1);
    end

    // Long single frame
    run_frame(2000, 1992, 0, 0, 1'b0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
